hwt_golden_monitor: RTL and testbench

Runtime checker on the observing end of the `non_hwt` cell's output. It recomputes the golden function Y = D & ((A & B) | C) for every applied input vector and compares it with the Y actually driven by the netlist instance. It counts vectors and mismatches, and escalates through a small state machine to a sticky alarm when mismatches persist. It sits beside each `non_hwt`/HWT-candidate instance in the trojan-detection bench and SoC wrappers.

---
 rtl/hwt_golden_monitor.sv | 135 +++++++++++++
 tb/tb_hwt_golden_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hwt_golden_monitor.sv
// hwt_golden_monitor
// Runtime checker for a non_hwt cell. It recomputes Y = D & ((A & B) | C) for
// every valid vector, compares it with the observed Y, counts vectors and
// mismatches, and escalates IDLE -> CHECK/SUSPECT -> ALARM on persistent
// mismatches. ALARM is sticky until clear or rst.
// Optional build macro: HWT_MON_COVERAGE_EN adds the 16-entry input
// coverage map. Without it, cov_map reads 16'h0000 and cov_full reads 0.
module hwt_golden_monitor #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_d,
  input  logic             y_obs,
  input  logic             clear,
  output logic             alarm,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      cov_map,
  output logic             cov_full
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_SUSPECT = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       RUN_MAX  = 8'hFF;
  localparam logic [7:0]       THRESH_L = 8'(THRESH);

  state_t           state_reg, state_next;
  logic [7:0]       run_reg, run_next;
  logic [CNT_W-1:0] vec_count_reg, vec_count_next;
  logic [CNT_W-1:0] err_count_reg, err_count_next;
  logic             golden;
  logic             mismatch;

  assign golden   = in_d & ((in_a & in_b) | in_c);
  assign mismatch = in_valid & (y_obs ^ golden);

  // Next-state, counter and run-length update for one valid vector
  always_comb begin
    state_next     = state_reg;
    run_next       = run_reg;
    vec_count_next = vec_count_reg;
    err_count_next = err_count_reg;
    if (in_valid) begin
      if (vec_count_reg != CNT_MAX) begin
        vec_count_next = vec_count_reg + CNT_W'(1);
      end
      if (mismatch) begin
        if (err_count_reg != CNT_MAX) begin
          err_count_next = err_count_reg + CNT_W'(1);
        end
        if (run_reg != RUN_MAX) begin
          run_next = run_reg + 8'd1;
        end
      end else begin
        run_next = 8'd0;
      end
      // ALARM is sticky; every other state is re-evaluated from the new run
      if (state_reg != ST_ALARM) begin
        if (run_next >= THRESH_L) begin
          state_next = ST_ALARM;
        end else if (run_next == 8'd0) begin
          state_next = ST_CHECK;
        end else begin
          state_next = ST_SUSPECT;
        end
      end
    end
  end

  // State and counter registers; rst and clear both discard the current vector
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg     <= ST_IDLE;
      run_reg       <= 8'd0;
      vec_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= run_next;
      vec_count_reg <= vec_count_next;
      err_count_reg <= err_count_next;
    end
  end

  assign alarm     = (state_reg == ST_ALARM);
  assign state     = state_reg;
  assign vec_count = vec_count_reg;
  assign err_count = err_count_reg;

`ifdef HWT_MON_COVERAGE_EN
  logic [15:0] cov_map_reg, cov_map_next;
  logic        cov_full_reg;
  logic [3:0]  vec_idx;

  assign vec_idx = {in_a, in_b, in_c, in_d};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cov
      assign cov_map_next[gi] = cov_map_reg[gi] | (in_valid & (vec_idx == 4'(gi)));
    end
  endgenerate

  // Coverage map and its full flag are registered together
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cov_map_reg  <= 16'h0000;
      cov_full_reg <= 1'b0;
    end else begin
      cov_map_reg  <= cov_map_next;
      cov_full_reg <= &cov_map_next;
    end
  end

  assign cov_map  = cov_map_reg;
  assign cov_full = cov_full_reg;
`else
  assign cov_map  = 16'h0000;
  assign cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_hwt_golden_monitor.sv
// Bench for hwt_golden_monitor: two instances share one stimulus stream,
// (CNT_W=8, THRESH=3) and (CNT_W=4, THRESH=1). A behavioural model tracks
// counts, consecutive-mismatch run length and alarm for each instance.
module tb_hwt_golden_monitor;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_a, in_b, in_c, in_d, y_obs, clear;
  logic        alarm0, alarm1, cov_full0, cov_full1;
  logic [1:0]  state0, state1;
  logic [7:0]  vec0, err0;
  logic [3:0]  vec1, err1;
  logic [15:0] cov0, cov1;

  int checks   = 0;
  int failures = 0;

  // model state, index 0 = default instance, 1 = CNT_W=4/THRESH=1 instance
  int m_vec[2], m_err[2], m_run[2];
  bit m_alarm[2], m_started[2];
  int m_cov;
  int cnt_max[2] = '{255, 15};
  int thr[2]     = '{3, 1};

  always #5 clk = ~clk;

  hwt_golden_monitor #(.CNT_W(8), .THRESH(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_d(in_d), .y_obs(y_obs), .clear(clear),
    .alarm(alarm0), .state(state0), .vec_count(vec0), .err_count(err0),
    .cov_map(cov0), .cov_full(cov_full0)
  );

  hwt_golden_monitor #(.CNT_W(4), .THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_d(in_d), .y_obs(y_obs), .clear(clear),
    .alarm(alarm1), .state(state1), .vec_count(vec1), .err_count(err1),
    .cov_map(cov1), .cov_full(cov_full1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int golden_of(input bit a, b, c, d);
    // Y is 1 when D holds and either both A and B, or C, hold
    if (!d) return 0;
    if (c) return 1;
    return (a && b) ? 1 : 0;
  endfunction

  function automatic int exp_state(input int i);
    if (m_alarm[i]) return 3;
    if (!m_started[i]) return 0;
    return (m_run[i] == 0) ? 1 : 2;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_vec[i] = 0; m_err[i] = 0; m_run[i] = 0;
      m_alarm[i] = 0; m_started[i] = 0;
    end
    m_cov = 0;
  endtask

  task automatic model_apply(input bit v, a, b, c, d, y, clr, r);
    bit mm;
    if (r || clr) begin
      model_clear();
      return;
    end
    if (!v) return;
    mm = (int'(y) != golden_of(a, b, c, d));
    m_cov = m_cov | (1 << {a, b, c, d});
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1;
      if (m_vec[i] < cnt_max[i]) m_vec[i]++;
      if (mm) begin
        if (m_err[i] < cnt_max[i]) m_err[i]++;
        if (m_run[i] < 255) m_run[i]++;
      end else begin
        m_run[i] = 0;
      end
      if (m_run[i] >= thr[i]) m_alarm[i] = 1;
    end
  endtask

  task automatic check_all();
    int ecov, efull;
`ifdef HWT_MON_COVERAGE_EN
    ecov  = m_cov;
    efull = (m_cov == 16'hFFFF) ? 1 : 0;
`else
    ecov  = 0;
    efull = 0;
`endif
    check("alarm0", 16'(alarm0), 16'(m_alarm[0]));
    check("state0", 16'(state0), 16'(exp_state(0)));
    check("vec0",   16'(vec0),   16'(m_vec[0]));
    check("err0",   16'(err0),   16'(m_err[0]));
    check("cov0",   cov0,        16'(ecov));
    check("full0",  16'(cov_full0), 16'(efull));
    check("alarm1", 16'(alarm1), 16'(m_alarm[1]));
    check("state1", 16'(state1), 16'(exp_state(1)));
    check("vec1",   16'(vec1),   16'(m_vec[1]));
    check("err1",   16'(err1),   16'(m_err[1]));
    check("cov1",   cov1,        16'(ecov));
    check("full1",  16'(cov_full1), 16'(efull));
  endtask

  // one clock of stimulus; outputs are sampled 1 time unit after the edge
  task automatic step(input bit v, a, b, c, d, y, clr, r);
    rst = r; clear = clr; in_valid = v;
    in_a = a; in_b = b; in_c = c; in_d = d; y_obs = y;
    @(posedge clk);
    model_apply(v, a, b, c, d, y, clr, r);
    #1;
    check_all();
  endtask

  task automatic vec(input int k, input bit flip);
    bit a, b, c, d, g;
    {a, b, c, d} = 4'(k);
    g = (golden_of(a, b, c, d) != 0);
    step(1'b1, a, b, c, d, g ^ flip, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_clear();
    // reset
    step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1, 1, 0, 1, 0, 1'b0, 1'b1);
    check("rst_state", 16'(state0), 16'd0);

    // all 16 vectors with correct Y
    for (int k = 0; k < 16; k++) vec(k, 1'b0);
    check("sweep_vec", 16'(vec0), 16'd16);
    check("sweep_state", 16'(state0), 16'd1);
    idle_cycle();

    // three consecutive mismatches on a=1,b=1,c=0,d=1 -> SUSPECT, SUSPECT, ALARM
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    vec(13, 1'b1);
    check("esc1", 16'(state0), 16'd2);
    idle_cycle();
    vec(13, 1'b1);
    check("esc2", 16'(state0), 16'd2);
    vec(13, 1'b1);
    check("esc3", 16'(state0), 16'd3);
    check("esc_err", 16'(err0), 16'd3);

    // five matching vectors while in ALARM, then clear with a valid vector
    for (int k = 0; k < 5; k++) vec(k * 3, 1'b0);
    check("alarm_hold", 16'(alarm0), 16'd1);
    check("alarm_vec", 16'(vec0), 16'd8);
    step(1'b1, 1, 1, 0, 1, 0, 1'b1, 1'b0);
    check("clr_vec", 16'(vec0), 16'd0);

    // mismatch, match, mismatch, mismatch never reaches ALARM on THRESH=3
    vec(7, 1'b1);
    vec(2, 1'b0);
    vec(9, 1'b1);
    vec(15, 1'b1);
    check("mmmm_state", 16'(state0), 16'd2);
    check("mmmm_err", 16'(err0), 16'd3);

    // rst together with a mismatch while in SUSPECT
    step(1'b1, 1, 1, 0, 1, 0, 1'b0, 1'b1);
    check("rst_mid", 16'(state0), 16'd0);

    // 20 mismatches: the 4-bit counters saturate at 15
    for (int k = 0; k < 20; k++) vec(k % 16, 1'b1);
    check("sat4_vec", 16'(vec1), 16'd15);
    check("sat4_err", 16'(err1), 16'd15);

    // long mismatching run saturates the 8-bit counters
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 270; k++) vec(int'($urandom_range(0, 15)), 1'b1);
    check("sat8_err", 16'(err0), 16'd255);
    vec(3, 1'b0);

    // randomized traffic with occasional clear and rst
    for (int n = 0; n < 600; n++) begin
      bit v, clr, r, fl;
      int k;
      bit a, b, c, d;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 59) == 0);
      r   = ($urandom_range(0, 89) == 0);
      fl  = ($urandom_range(0, 2) == 0);
      k   = int'($urandom_range(0, 15));
      {a, b, c, d} = 4'(k);
      step(v, a, b, c, d, (golden_of(a, b, c, d) != 0) ^ fl, clr, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
